seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 168 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed, active-low 7-segment display bus
// (segments + digit anodes), waits for each digit to be stable, decodes it
// and publishes a complete 4-digit frame once all digits have been seen.
module seg_scan_decoder #(
   parameter int unsigned SETTLE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg_in,
   input  logic [3:0]  an_in,
   output logic [15:0] dec_out,
   output logic [3:0]  dp_out,
   output logic [3:0]  err_out,
   output logic        frame_valid
);

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  seg_r, seg_p;
   logic [3:0]  an_r, an_p;
   logic [7:0]  cnt, cnt_nxt;
   logic        wait_flag;
   logic [3:0]  wait_an;
   logic [3:0]  seen, seen_nxt;
   logic [15:0] work_dec;
   logic [3:0]  work_dp, work_err;
   logic        an_legal, changed, capture;
   logic [3:0]  code;
   logic        code_err;
   logic [1:0]  digit_idx;

   // Input stage plus a one-cycle history used for stability detection.
   // NOTE: sequential state is always assigned with <= so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_r <= 8'hFF;
         an_r  <= 4'hF;
         seg_p <= 8'hFF;
         an_p  <= 4'hF;
      end else begin
         seg_r <= seg_in;
         an_r  <= an_in;
         seg_p <= seg_r;
         an_p  <= an_r;
      end
   end

   assign an_legal = (an_r == 4'b1110) || (an_r == 4'b1101) ||
                     (an_r == 4'b1011) || (an_r == 4'b0111);
   assign changed  = {seg_r, an_r} != {seg_p, an_p};

   // Next-state and settle-counter logic.
   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            // After a capture, stay parked until the selected digit changes.
            if (!(wait_flag && an_r == wait_an) && an_legal) begin
               state_nxt = S_SETTLE;
               cnt_nxt   = 8'd1;
            end
         end
         S_SETTLE: begin
            if (!an_legal) begin
               state_nxt = S_IDLE;
            end else if (changed) begin
               cnt_nxt = 8'd1;
            end else begin
               cnt_nxt = cnt + 8'd1;
               if (cnt_nxt == SETTLE_C) state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            capture   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register, settle counter and the post-capture wait condition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         wait_flag <= 1'b0;
         wait_an   <= 4'hF;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (capture) begin
            wait_flag <= 1'b1;
            wait_an   <= an_p;
         end else if (state == S_IDLE && wait_flag && an_r != wait_an) begin
            wait_flag <= 1'b0;
         end
      end
   end

   // Segment decoder; in CAPTURE the previous-cycle sample holds the settled value.
   always_comb begin
      code     = 4'hF;
      code_err = 1'b0;
      case (seg_p[7:1])
         7'b0000001: code = 4'h0;
         7'b1001111: code = 4'h1;
         7'b0010010: code = 4'h2;
         7'b0000110: code = 4'h3;
         7'b1001100: code = 4'h4;
         7'b0100100: code = 4'h5;
         7'b0100000: code = 4'h6;
         7'b0001111: code = 4'h7;
         7'b0000000: code = 4'h8;
         7'b0000100: code = 4'h9;
         7'b1111111: code = 4'hA;
         default:    code_err = 1'b1;
      endcase
      case (an_p)
         4'b1101: digit_idx = 2'd1;
         4'b1011: digit_idx = 2'd2;
         4'b0111: digit_idx = 2'd3;
         default: digit_idx = 2'd0;
      endcase
   end

   // Seen bits clear on publication; a capture in the same cycle still registers.
   always_comb begin
      seen_nxt = (seen == 4'hF) ? 4'h0 : seen;
      if (capture) seen_nxt[digit_idx] = 1'b1;
   end

   // Working frame, seen tracking and frame publication.
   always_ff @(posedge clk) begin
      if (rst) begin
         seen        <= 4'h0;
         work_dec    <= 16'h0000;
         work_dp     <= 4'h0;
         work_err    <= 4'h0;
         dec_out     <= 16'h0000;
         dp_out      <= 4'h0;
         err_out     <= 4'h0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         seen        <= seen_nxt;
         if (seen == 4'hF) begin
            dec_out     <= work_dec;
            dp_out      <= work_dp;
            err_out     <= work_err;
            frame_valid <= 1'b1;
         end
         if (capture) begin
            work_dec[{digit_idx, 2'b00} +: 4] <= code;
            work_dp[digit_idx]                <= ~seg_p[0];
            work_err[digit_idx]               <= code_err;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: each scan pushes its expected frame,
// a monitor pops on frame_valid and otherwise checks the outputs hold.
module tb_seg_scan_decoder;

   localparam int SETTLE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  seg_in;
   logic [3:0]  an_in;
   logic [15:0] dec_out;
   logic [3:0]  dp_out, err_out;
   logic        frame_valid;

   typedef struct {
      logic [15:0] dec;
      logic [3:0]  dp;
      logic [3:0]  err;
   } frame_t;

   frame_t exp_q[$];
   frame_t held;
   int     n_checks = 0;
   int     n_fail   = 0;
   int     frames   = 0;
   int     pushed   = 0;
   bit     mon_en   = 1'b0;

   // Active-low segment patterns a..g for 0..9 and blank (index 10).
   localparam logic [6:0] PAT [11] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
      7'b1111111 };

   seg_scan_decoder #(.SETTLE(SETTLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .an_in       (an_in),
      .dec_out     (dec_out),
      .dp_out      (dp_out),
      .err_out     (err_out),
      .frame_valid (frame_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] seg_of(input int v, input bit dp_lit);
      return {PAT[v], ~dp_lit};
   endfunction

   // Monitor: pop and compare on each published frame, otherwise outputs hold.
   always @(negedge clk) begin
      if (mon_en) begin
         if (frame_valid === 1'b1) begin
            frames++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: got dec %h expected no frame", dec_out);
            end else begin
               frame_t e;
               e = exp_q.pop_front();
               check("frame_dec", 32'(dec_out), 32'(e.dec));
               check("frame_dp",  32'(dp_out),  32'(e.dp));
               check("frame_err", 32'(err_out), 32'(e.err));
               held = e;
            end
         end else begin
            check("hold_dec", 32'(dec_out), 32'(held.dec));
            check("hold_dp",  32'(dp_out),  32'(held.dp));
            check("hold_err", 32'(err_out), 32'(held.err));
         end
      end
   end

   // Called at a negedge; holds the pattern for the given number of cycles.
   task automatic drive(input logic [7:0] s, input logic [3:0] a, input int cycles);
      seg_in = s;
      an_in  = a;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic digit(input int d, input logic [7:0] s, input int cycles);
      drive(s, ~(4'b0001 << d), cycles);
   endtask

   task automatic idle(input int cycles);
      drive(8'hFF, 4'hF, cycles);
   endtask

   task automatic expect_frame(input logic [15:0] dec, input logic [3:0] dp, input logic [3:0] err);
      frame_t f;
      f.dec = dec;
      f.dp  = dp;
      f.err = err;
      exp_q.push_back(f);
      pushed++;
   endtask

   task automatic settle_check(input string name);
      idle(10);
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      check({name, "_frames"},  32'(frames), 32'(pushed));
   endtask

   initial begin
      rst    = 1'b1;
      seg_in = 8'hFF;
      an_in  = 4'hF;
      held   = '{16'h0, 4'h0, 4'h0};
      repeat (3) @(negedge clk);
      check("reset_dec", 32'(dec_out), 32'h0);
      check("reset_dp",  32'(dp_out),  32'h0);
      check("reset_err", 32'(err_out), 32'h0);
      check("reset_fv",  32'(frame_valid), 32'h0);
      rst    = 1'b0;
      mon_en = 1'b1;
      idle(5);

      // Basic scan 1,2,3,4.
      expect_frame(16'h4321, 4'h0, 4'h0);
      digit(0, 8'b10011111, 10);
      digit(1, 8'b00100101, 10);
      digit(2, 8'b00001101, 10);
      digit(3, 8'b10011001, 10);
      settle_check("scan_1234");

      // Digit 0 held SETTLE-1 cycles is not captured, so no frame yet.
      digit(0, seg_of(7, 0), SETTLE - 1);
      digit(1, seg_of(5, 0), 10);
      digit(2, seg_of(6, 0), 10);
      digit(3, seg_of(7, 0), 10);
      settle_check("short_hold");
      expect_frame(16'h7658, 4'h0, 4'h0);
      digit(0, seg_of(8, 0), 10);
      settle_check("short_hold_complete");

      // Illegal pattern on digit 2: only g lit, dp lit.
      expect_frame(16'h7F65, 4'b0100, 4'b0100);
      digit(0, seg_of(5, 0), 10);
      digit(1, seg_of(6, 0), 10);
      digit(2, 8'b11111100, 10);
      digit(3, seg_of(7, 0), 10);
      settle_check("illegal_digit2");

      // Two anodes low: never captured.
      drive(seg_of(3, 1), 4'b1100, 20);
      settle_check("multi_anode");

      // Blank digit with dp lit on digit 1.
      expect_frame(16'h98A0, 4'b0010, 4'h0);
      digit(0, seg_of(0, 0), 10);
      digit(1, seg_of(10, 1), 10);
      digit(2, seg_of(8, 0), 10);
      digit(3, seg_of(9, 0), 10);
      settle_check("blank_dp");

      // Recapture of digit 0 before frame completes: latest wins.
      expect_frame(16'h4329, 4'h0, 4'h0);
      digit(0, seg_of(1, 0), 10);
      digit(1, seg_of(2, 0), 10);
      digit(0, seg_of(9, 0), 10);
      digit(2, seg_of(3, 0), 10);
      digit(3, seg_of(4, 0), 10);
      settle_check("recapture");

      // Reset after three captures discards them.
      digit(0, seg_of(1, 0), 10);
      digit(1, seg_of(1, 0), 10);
      digit(2, seg_of(1, 0), 10);
      seg_in = 8'hFF;
      an_in  = 4'hF;
      rst    = 1'b1;
      @(posedge clk);
      #1 held = '{16'h0, 4'h0, 4'h0};
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_reset_dec", 32'(dec_out), 32'h0);
      digit(3, seg_of(2, 0), 10);
      settle_check("post_reset_partial");
      check("post_reset_partial_dec", 32'(dec_out), 32'h0);
      expect_frame(16'h2765, 4'h0, 4'h0);
      digit(0, seg_of(5, 0), 10);
      digit(1, seg_of(6, 0), 10);
      digit(2, seg_of(7, 0), 10);
      settle_check("post_reset_full");

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
